// File: rtl/riscv_boot_pkg.sv
// Shared definitions for the boot-time instruction loader.
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-lane counter and little-endian word assembler; word_complete_o
// pulses combinationally with the byte that finishes a word.
module loader_word_asm
  import riscv_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_complete_o
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [23:0]       shift_q, shift_d;

  // Only the first three bytes are stored; the fourth is taken straight from
  // the input so the full word is ready in the same cycle it completes.
  assign word_o          = {byte_data_i, shift_q};
  assign word_complete_o = byte_en_i && (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear_i) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_en_i) begin
      lane_d  = lane_q + 1'b1;
      shift_d = {byte_data_i, shift_q[23:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/insn_loader.sv
// Boot loader: parses a counted, XOR-checksummed byte image into instruction
// memory and holds the core in reset until a verified image is in place.
module insn_loader
  import riscv_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  err,
  output logic                  done
);

  localparam int          CW       = ADDR_WIDTH + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [15:0]           n_q, n_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [7:0]            xor_q, xor_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;

  logic        accept;
  logic        asm_en;
  logic        asm_clear;
  logic [31:0] asm_word;
  logic        asm_complete;
  logic [15:0] hdr_n;
  logic        last_word;

  assign byte_ready = (state_q != RUN);
  assign accept     = byte_valid && byte_ready;
  assign asm_en     = accept && (state_q == DATA);
  assign hdr_n      = {byte_data, cnt_lo_q};
  assign last_word  = (17'(wcnt_q) + 17'd1) == {1'b0, n_q};

  loader_word_asm u_word_asm (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (asm_clear),
    .byte_en_i       (asm_en),
    .byte_data_i     (byte_data),
    .word_o          (asm_word),
    .word_complete_o (asm_complete)
  );

  always_comb begin
    state_d   = state_q;
    cnt_lo_d  = cnt_lo_q;
    n_d       = n_q;
    wcnt_d    = wcnt_q;
    xor_d     = xor_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
    case (state_q)
      HDR0: if (accept) begin
        cnt_lo_d = byte_data;
        state_d  = HDR1;
      end
      HDR1: if (accept) begin
        n_d = hdr_n;
        if ({1'b0, hdr_n} > CAPACITY) state_d = ERROR;
        else if (hdr_n == 16'd0)      state_d = CSUM;
        else                          state_d = DATA;
      end
      DATA: if (accept) begin
        xor_d = xor_q ^ byte_data;
        if (asm_complete) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_WIDTH-1:0];
          wdata_d = asm_word;
          wcnt_d  = wcnt_q + 1'b1;
          if (last_word) state_d = CSUM;
        end
      end
      CSUM: if (accept) begin
        state_d = (byte_data == xor_q) ? RUN : ERROR;
      end
      RUN, ERROR: if (reload) begin
        // Memory is left as-is; only the parse state restarts.
        state_d   = HDR0;
        wcnt_d    = '0;
        xor_d     = '0;
        asm_clear = 1'b1;
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HDR0;
      cnt_lo_q <= '0;
      n_q      <= '0;
      wcnt_q   <= '0;
      xor_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      n_q      <= n_d;
      wcnt_q   <= wcnt_d;
      xor_q    <= xor_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = (state_q == RUN);
  assign done       = (state_q == RUN);
  assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_insn_loader.sv
// Randomised bench for insn_loader: a byte-position image parser model is
// compared against the DUT every cycle, plus literal checks on known images.
module tb_insn_loader;
  import riscv_boot_pkg::*;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;
  localparam int PH_LOAD = 0, PH_RUN = 1, PH_ERR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          reload = 1'b0;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          err;
  logic          done;

  insn_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .err        (err),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: interprets the stream purely by byte position in the image.
  int          m_phase = PH_LOAD;
  int          m_idx   = 0;
  int          m_n     = 0;
  int          m_k     = 0;
  logic [7:0]  m_nlo   = 8'h00;
  logic [7:0]  m_xor   = 8'h00;
  logic [31:0] m_word  = 32'h0;
  logic        m_we    = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = PH_LOAD; m_idx = 0; m_xor = 8'h00;
      m_we = 1'b0; m_addr = '0; m_wdata = 32'h0;
    end else begin
      m_we = 1'b0;
      if (m_phase != PH_LOAD && reload) begin
        m_phase = PH_LOAD; m_idx = 0; m_xor = 8'h00;
      end else if (byte_valid && m_phase == PH_LOAD) begin
        if (m_idx == 0) m_nlo = byte_data;
        else if (m_idx == 1) begin
          m_n = int'({byte_data, m_nlo});
          if (m_n > CAP) m_phase = PH_ERR;
        end else if (m_idx < HDR_BYTES + BYTES_PER_WORD * m_n) begin
          m_k = m_idx - HDR_BYTES;
          m_xor = m_xor ^ byte_data;
          m_word[8*(m_k%4) +: 8] = byte_data;
          if (m_k % 4 == 3) begin
            m_we = 1'b1; m_addr = AW'(m_k / 4); m_wdata = m_word;
          end
        end else begin
          m_phase = (byte_data == m_xor) ? PH_RUN : PH_ERR;
        end
        m_idx++;
      end
    end
  end

  logic        cmp_on = 1'b0;
  logic [31:0] seen_mem [CAP];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("byte_ready", 32'(byte_ready), 32'(m_phase != PH_RUN));
      chk("imem_we",    32'(imem_we),    32'(m_we));
      chk("imem_addr",  32'(imem_addr),  32'(m_addr));
      chk("imem_wdata", imem_wdata,      m_wdata);
      chk("core_rst_n", 32'(core_rst_n), 32'(m_phase == PH_RUN));
      chk("done",       32'(done),       32'(m_phase == PH_RUN));
      chk("err",        32'(err),        32'(m_phase == PH_ERR));
      if (imem_we) seen_mem[imem_addr] = imem_wdata;
    end
  end

  logic [31:0] img [CAP];
  logic [7:0]  q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input int gmax);
    int gap;
    gap = (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    repeat (gap) begin
      byte_data = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_q(input int gmax);
    foreach (q[i]) put_byte(q[i], gmax);
  endtask

  task automatic send_image(input int n, input int gmax, input logic bad);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [15:0] n16;
    n16 = 16'(n);
    x = 8'h00;
    q.delete();
    q.push_back(n16[7:0]);
    q.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = img[i][8*j +: 8];
        q.push_back(b);
        x = x ^ b;
      end
    end
    q.push_back(bad ? (x ^ 8'h01) : x);
    send_q(gmax);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " byte_ready"}, 32'(byte_ready), 32'd1);
    chk({tag, " imem_we"},    32'(imem_we),    32'd0);
    chk({tag, " imem_addr"},  32'(imem_addr),  32'd0);
    chk({tag, " imem_wdata"}, imem_wdata,      32'd0);
    chk({tag, " core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, " err"},        32'(err),        32'd0);
    chk({tag, " done"},       32'(done),       32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic bad;
    int   n;
    for (int i = 0; i < CAP; i++) seen_mem[i] = NOP_INSN;

    rst = 1'b1;
    tick();
    cmp_on = 1'b1;
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Known image: payload XOR is 0x13 ^ 0x93 ^ 0x10 = 0x90.
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_q(0);
    chk("imgA core_rst_n", 32'(core_rst_n), 32'd1);
    chk("imgA done",       32'(done),       32'd1);
    tick();
    chk("imgA mem0", seen_mem[0], 32'h00000013);
    chk("imgA mem1", seen_mem[1], 32'h00100093);

    // Bytes offered in RUN are not consumed, even together with reload.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) tick();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    byte_valid = 1'b0;
    chk("reload core_rst_n", 32'(core_rst_n), 32'd0);
    chk("reload done",       32'(done),       32'd0);

    // Same image, wrong checksum.
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
    send_q(0);
    chk("badcsum err",        32'(err),        32'd1);
    chk("badcsum core_rst_n", 32'(core_rst_n), 32'd0);
    for (int i = 0; i < 6; i++) put_byte(8'($urandom), 1);
    chk("drain err", 32'(err), 32'd1);
    do_reload();

    // Empty image.
    q = '{8'h00, 8'h00, 8'h00};
    send_q(0);
    chk("empty done", 32'(done), 32'd1);
    do_reload();

    // One word too many for the memory.
    q = '{8'h01, 8'h04};
    send_q(0);
    chk("oversize err", 32'(err), 32'd1);
    do_reload();

    // Random images, alternating back-to-back and gappy delivery.
    for (int it = 0; it < 10; it++) begin
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      bad = ($urandom_range(3, 0) == 0);
      send_image(n, (it % 2 == 1) ? 3 : 0, bad);
      tick();
      chk("rand done", 32'(done), 32'(!bad));
      for (int i = 0; i < n; i++) chk("rand mem", seen_mem[i], img[i]);
      do_reload();
    end

    // Reset in the middle of a load, then a clean load.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    q = '{8'h03, 8'h00};
    for (int j = 0; j < 6; j++) q.push_back(8'($urandom));
    send_q(0);
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    send_image(3, 2, 1'b0);
    tick();
    chk("postrst done", 32'(done), 32'd1);
    chk("postrst mem2", seen_mem[2], img[2]);

    // Image that fills memory exactly.
    do_reload();
    for (int i = 0; i < CAP; i++) img[i] = $urandom;
    send_image(CAP, 0, 1'b0);
    chk("full done",      32'(done),      32'd1);
    chk("full last addr", 32'(imem_addr), 32'(CAP - 1));
    chk("full mem0",      seen_mem[0],       img[0]);
    chk("full memlast",   seen_mem[CAP - 1], img[CAP - 1]);

    // Reload and overwrite address 0.
    do_reload();
    chk("reload2 core_rst_n", 32'(core_rst_n), 32'd0);
    img[0] = 32'hDEADBEEF;
    send_image(1, 0, 1'b0);
    tick();
    chk("overwrite mem0", seen_mem[0], 32'hDEADBEEF);
    chk("overwrite done", 32'(done), 32'd1);
    chk("stale mem1",     seen_mem[1], img[1]);

    tick();
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
